// File: rtl/pwm_core_dt_if.sv
// Configuration and status bundle for one PWM leg.
// The master drives configuration; the slave (PWM core) drives carrier and gate outputs.
interface pwm_core_dt_if #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 5,
    parameter int DT_W  = 8
);
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] init_carr;
    logic [WIDTH-1:0] compare;
    logic [DIV_W-1:0] clk_divider;
    logic [DT_W-1:0]  dead_time;
    logic [1:0]       count_mode;
    logic [1:0]       mask_mode;
    logic             pwm_onoff;
    logic [WIDTH-1:0] carrier;
    logic             mask_event;
    logic             pwm_h;
    logic             pwm_l;

    modport master (
        output period, init_carr, compare, clk_divider, dead_time,
               count_mode, mask_mode, pwm_onoff,
        input  carrier, mask_event, pwm_h, pwm_l
    );

    modport slave (
        input  period, init_carr, compare, clk_divider, dead_time,
               count_mode, mask_mode, pwm_onoff,
        output carrier, mask_event, pwm_h, pwm_l
    );
endinterface

// File: rtl/pwm_core_dt.sv
// PWM channel: prescaled up/down/up-down carrier, shadowed period/compare,
// and complementary gate outputs with a dead-time gap on every raw edge.
module pwm_core_dt #(
    parameter int WIDTH = 16,
    parameter int DIV_W = 5,
    parameter int DT_W  = 8
) (
    input  logic          clk,
    input  logic          reset,
    pwm_core_dt_if.slave  bus
);
    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam logic [DIV_W-1:0] D_ONE = DIV_W'(1);
    localparam logic [DT_W-1:0]  T_ONE = DT_W'(1);

    logic [DIV_W-1:0] presc_reg;
    logic [WIDTH-1:0] carrier_reg, carrier_next;
    logic [WIDTH-1:0] period_sh_reg, compare_sh_reg;
    dir_t             dir_reg, dir_next;
    logic [DT_W-1:0]  dt_cnt_reg;
    logic             r_prev_reg, pwm_h_reg, pwm_l_reg;

    logic             tick, zero_ev, per_ev, mask_match, load_now, raw;
    logic [WIDTH-1:0] init_clamped;

    // Tick is gated by reset so no load pulse can escape while reset is held.
    assign tick    = bus.pwm_onoff & ~reset & (presc_reg >= bus.clk_divider);
    assign zero_ev = (carrier_reg == '0);
    assign per_ev  = (carrier_reg == period_sh_reg);
    assign raw     = (carrier_reg < compare_sh_reg);
    assign init_clamped = (bus.init_carr > bus.period) ? bus.period : bus.init_carr;

    always_comb begin
        mask_match = 1'b1;
        case (bus.mask_mode)
            2'b00:   mask_match = zero_ev;
            2'b01:   mask_match = per_ev;
            2'b10:   mask_match = zero_ev | per_ev;
            default: mask_match = 1'b1;
        endcase
    end

    assign load_now = tick & mask_match;

    always_comb begin
        carrier_next = carrier_reg;
        dir_next     = dir_reg;
        case (bus.count_mode)
            2'b01: begin
                carrier_next = (zero_ev || carrier_reg > period_sh_reg) ?
                               period_sh_reg : carrier_reg - C_ONE;
            end
            2'b10: begin
                // Turning points are emitted once so a full cycle lasts 2P ticks.
                if (dir_reg == DIR_UP) begin
                    if (carrier_reg >= period_sh_reg) begin
                        carrier_next = (period_sh_reg == '0) ? '0 : period_sh_reg - C_ONE;
                        dir_next     = DIR_DOWN;
                    end else begin
                        carrier_next = carrier_reg + C_ONE;
                    end
                end else begin
                    if (zero_ev) begin
                        carrier_next = (period_sh_reg == '0) ? '0 : C_ONE;
                        dir_next     = DIR_UP;
                    end else begin
                        carrier_next = carrier_reg - C_ONE;
                    end
                end
            end
            default: begin
                carrier_next = (carrier_reg >= period_sh_reg) ? '0 : carrier_reg + C_ONE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg      <= '0;
            carrier_reg    <= '0;
            period_sh_reg  <= '0;
            compare_sh_reg <= '0;
            dir_reg        <= DIR_UP;
        end else if (!bus.pwm_onoff) begin
            presc_reg      <= '0;
            period_sh_reg  <= bus.period;
            compare_sh_reg <= bus.compare;
            carrier_reg    <= init_clamped;
            dir_reg        <= DIR_UP;
        end else begin
            presc_reg <= (presc_reg >= bus.clk_divider) ? '0 : presc_reg + D_ONE;
            if (tick) begin
                carrier_reg <= carrier_next;
                dir_reg     <= dir_next;
            end
            if (load_now) begin
                period_sh_reg  <= bus.period;
                compare_sh_reg <= bus.compare;
            end
        end
    end

    // While stopped, r_prev holds the inverse of raw so the first running
    // cycle is seen as an edge and the outputs enter through a dead-time gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dt_cnt_reg <= '0;
            r_prev_reg <= 1'b0;
            pwm_h_reg  <= 1'b0;
            pwm_l_reg  <= 1'b0;
        end else if (!bus.pwm_onoff) begin
            dt_cnt_reg <= '0;
            r_prev_reg <= ~raw;
            pwm_h_reg  <= 1'b0;
            pwm_l_reg  <= 1'b0;
        end else if (raw != r_prev_reg) begin
            r_prev_reg <= raw;
            if (bus.dead_time == '0) begin
                dt_cnt_reg <= '0;
                pwm_h_reg  <= raw;
                pwm_l_reg  <= ~raw;
            end else begin
                dt_cnt_reg <= bus.dead_time;
                pwm_h_reg  <= 1'b0;
                pwm_l_reg  <= 1'b0;
            end
        end else if (dt_cnt_reg != '0) begin
            dt_cnt_reg <= dt_cnt_reg - T_ONE;
            if (dt_cnt_reg == T_ONE) begin
                pwm_h_reg <= r_prev_reg;
                pwm_l_reg <= ~r_prev_reg;
            end
        end
    end

    assign bus.carrier    = carrier_reg;
    assign bus.mask_event = load_now;
    assign bus.pwm_h      = pwm_h_reg;
    assign bus.pwm_l      = pwm_l_reg;
endmodule
